// File: rtl/pong_pkg.sv
// Shared Pong constants: screen/paddle geometry (matches the VGA generator), centre point, FSM states.
// Pure declarations; no timing or flow control.
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BAR_W        = 10;
  localparam int BAR_H        = 40;
  localparam int ADC_BITS     = 12;
  localparam int BALL_DX      = 2;
  localparam int BALL_DY      = 1;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;
  localparam int BALL_DX_MAX  = 6;

  localparam logic [9:0] CENTRE_X   = 10'(SCREEN_W / 2);
  localparam logic [8:0] CENTRE_Y   = 9'(SCREEN_H / 2);
  localparam logic [8:0] PADDLE_MAX = 9'(SCREEN_H - BAR_H);
  localparam logic [8:0] PADDLE_RST = 9'((SCREEN_H - BAR_H) / 2);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/pong_paddle_scale.sv
// Maps a raw ADC sample to a paddle top Y: keep the top 9 bits, clamp so the paddle stays on screen.
// Purely combinational; no backpressure.
module pong_paddle_scale
  import pong_pkg::*;
(
  input  logic [ADC_BITS-1:0] adc_i,
  output logic [8:0]          y_o
);

  logic [8:0] shifted;

  assign shifted = adc_i[ADC_BITS-1 -: 9];
  assign y_o     = (shifted > PADDLE_MAX) ? PADDLE_MAX : shifted;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game logic: paddles, ball physics, scoring, serve/game-over FSM; PONG_SPEEDUP_EN adds ball speed-up.
// All state advances on the vsync falling edge; outputs settle 1 clk later. No backpressure (frame-paced).
module pong_game_engine
  import pong_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vga_vs,
  input  logic [ADC_BITS-1:0] adc_p1,
  input  logic [ADC_BITS-1:0] adc_p2,
  input  logic                start_n,
  output logic [15:0]         pongbar1_y,
  output logic [15:0]         pongbar2_y,
  output logic [15:0]         bal_x,
  output logic [15:0]         bal_y,
  output logic [3:0]          score_l,
  output logic [3:0]          score_r,
  output logic                game_over
);

  state_e     state_q, state_d;
  logic       vs_q, tick;
  logic [1:0] start_sync_q;
  logic       start_s;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d, p1_q, p1_d, p2_q, p2_d, p1_new, p2_new;
  logic       dirx_q, dirx_d, diry_q, diry_d;  // 1 = right / 1 = down
  logic [3:0] sl_q, sl_d, sr_q, sr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] dx;
  logic [9:0] y_step;
  logic       at_left, at_right, hit_l, hit_r;
  logic       miss, serve_done, restart, win;

  pong_paddle_scale u_scale_p1 (.adc_i(adc_p1), .y_o(p1_new));
  pong_paddle_scale u_scale_p2 (.adc_i(adc_p2), .y_o(p2_new));

  assign tick    = vs_q & ~vga_vs;
  assign start_s = start_sync_q[1];
  assign y_step  = {1'b0, y_q} + 10'(BALL_DY);

  // Collisions use last frame's paddles and the ball Y before this tick's move.
  assign at_left  = !dirx_q && (x_q < 10'(BAR_W) + 10'(dx));
  assign at_right =  dirx_q && (x_q + 10'(dx) > 10'(SCREEN_W - 1 - BAR_W));
  assign hit_l    = (y_q >= p1_q) && ({1'b0, y_q} < {1'b0, p1_q} + 10'(BAR_H));
  assign hit_r    = (y_q >= p2_q) && ({1'b0, y_q} < {1'b0, p2_q} + 10'(BAR_H));
  assign win      = (sl_d == 4'(WIN_SCORE)) || (sr_d == 4'(WIN_SCORE));

`ifdef PONG_SPEEDUP_EN
  logic [2:0] dx_q, dx_d;
  logic [1:0] hits_q, hits_d;
  logic       hit;

  assign dx  = dx_q;
  assign hit = tick && (state_q == PLAY) && ((at_left && hit_l) || (at_right && hit_r));

  always_comb begin
    hits_d = hits_q;
    dx_d   = dx_q;
    if (state_d == SERVE && state_q != SERVE) begin
      hits_d = 2'd0;
      dx_d   = 3'(BALL_DX);
    end else if (hit) begin
      hits_d = hits_q + 2'd1;
      if (hits_q == 2'd3 && dx_q < 3'(BALL_DX_MAX)) dx_d = dx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dx_q   <= 3'(BALL_DX);
      hits_q <= 2'd0;
    end else begin
      dx_q   <= dx_d;
      hits_q <= hits_d;
    end
  end
`else
  assign dx = 3'(BALL_DX);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SERVE;
      vs_q         <= 1'b1;
      start_sync_q <= 2'b11;
      x_q          <= CENTRE_X;
      y_q          <= CENTRE_Y;
      p1_q         <= PADDLE_RST;
      p2_q         <= PADDLE_RST;
      dirx_q       <= 1'b1;
      diry_q       <= 1'b1;
      sl_q         <= 4'd0;
      sr_q         <= 4'd0;
      cnt_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vga_vs;
      start_sync_q <= {start_sync_q[0], start_n};
      x_q          <= x_d;
      y_q          <= y_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      dirx_q       <= dirx_d;
      diry_q       <= diry_d;
      sl_q         <= sl_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE:     if (serve_done) state_d = PLAY;
      PLAY:      if (miss) state_d = win ? GAME_OVER : SERVE;
      GAME_OVER: if (restart) state_d = SERVE;
      default:   state_d = SERVE;
    endcase
  end

  always_comb begin
    x_d = x_q;  y_d = y_q;  p1_d = p1_q;  p2_d = p2_q;
    dirx_d = dirx_q;  diry_d = diry_q;
    sl_d = sl_q;  sr_d = sr_q;  cnt_d = cnt_q;
    miss = 1'b0;  serve_done = 1'b0;  restart = 1'b0;
    if (tick) begin
      p1_d = p1_new;
      p2_d = p2_new;
      case (state_q)
        SERVE: begin
          x_d = CENTRE_X;
          y_d = CENTRE_Y;
          if (cnt_q == 6'(SERVE_FRAMES - 1)) begin
            cnt_d      = 6'd0;
            serve_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        PLAY: begin
          if (diry_q) begin
            if (y_step >= 10'(SCREEN_H - 1)) begin
              y_d = 9'(SCREEN_H - 1);  diry_d = 1'b0;
            end else begin
              y_d = y_step[8:0];
            end
          end else if (y_q <= 9'(BALL_DY)) begin
            y_d = 9'd0;  diry_d = 1'b1;
          end else begin
            y_d = y_q - 9'(BALL_DY);
          end
          if (at_left) begin
            if (hit_l) begin
              x_d = 10'(BAR_W);  dirx_d = 1'b1;
            end else begin
              sr_d = sr_q + 4'd1;  dirx_d = 1'b0;  miss = 1'b1;
            end
          end else if (at_right) begin
            if (hit_r) begin
              x_d = 10'(SCREEN_W - 1 - BAR_W);  dirx_d = 1'b0;
            end else begin
              sl_d = sl_q + 4'd1;  dirx_d = 1'b1;  miss = 1'b1;
            end
          end else begin
            x_d = dirx_q ? x_q + 10'(dx) : x_q - 10'(dx);
          end
          if (miss) begin
            x_d = CENTRE_X;  y_d = CENTRE_Y;  cnt_d = 6'd0;
          end
        end
        default: begin
          x_d = CENTRE_X;
          y_d = CENTRE_Y;
          if (!start_s) begin
            sl_d = 4'd0;  sr_d = 4'd0;  dirx_d = 1'b1;  cnt_d = 6'd0;  restart = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    game_over = (state_q == GAME_OVER);
  end

  assign pongbar1_y = {7'd0, p1_q};
  assign pongbar2_y = {7'd0, p2_q};
  assign bal_x      = {6'd0, x_q};
  assign bal_y      = {7'd0, y_q};
  assign score_l    = sl_q;
  assign score_r    = sr_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomised frame stimulus against a velocity-based Pong reference model; a monitor compares each frame's outputs.
module tb_pong_game_engine;

  logic        clk = 1'b0;
  logic        reset_n, vga_vs, start_n;
  logic [11:0] adc_p1, adc_p2;
  logic [15:0] pongbar1_y, pongbar2_y, bal_x, bal_y;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  pong_game_engine dut (
    .clk(clk), .reset_n(reset_n), .vga_vs(vga_vs),
    .adc_p1(adc_p1), .adc_p2(adc_p2), .start_n(start_n),
    .pongbar1_y(pongbar1_y), .pongbar2_y(pongbar2_y),
    .bal_x(bal_x), .bal_y(bal_y),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p1, p2, bx, by, sl, sr, go;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: ball as position + signed velocity; mode 0 serve, 1 play, 2 game over.
  int m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_mode, m_cnt, m_p1, m_p2;

  task automatic m_reset();
    m_bx = 320; m_by = 240; m_vx = 2; m_vy = 1;
    m_sl = 0; m_sr = 0; m_mode = 0; m_cnt = 0; m_p1 = 220; m_p2 = 220;
  endtask

  task automatic m_step(input int a1, input int a2, input bit st_n);
    int np1, np2, oy, nx, ny;
    bit miss;
    np1 = (a1 / 8 > 440) ? 440 : a1 / 8;
    np2 = (a2 / 8 > 440) ? 440 : a2 / 8;
    miss = 1'b0;
    if (m_mode == 0) begin
      m_bx = 320; m_by = 240;
      m_cnt++;
      if (m_cnt == 60) begin m_cnt = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      oy = m_by;
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      if (ny >= 479)    begin m_by = 479; m_vy = -1; end
      else if (ny <= 0) begin m_by = 0;   m_vy = 1;  end
      else m_by = ny;
      if (nx < 10) begin
        if (oy >= m_p1 && oy < m_p1 + 40) begin m_bx = 10; m_vx = 2; end
        else begin m_sr++; m_vx = -2; miss = 1'b1; end
      end else if (nx > 629) begin
        if (oy >= m_p2 && oy < m_p2 + 40) begin m_bx = 629; m_vx = -2; end
        else begin m_sl++; m_vx = 2; miss = 1'b1; end
      end else m_bx = nx;
      if (miss) begin
        m_bx = 320; m_by = 240; m_cnt = 0;
        m_mode = (m_sl == 9 || m_sr == 9) ? 2 : 0;
      end
    end else begin
      m_bx = 320; m_by = 240;
      if (!st_n) begin m_sl = 0; m_sr = 0; m_vx = 2; m_cnt = 0; m_mode = 0; end
    end
    m_p1 = np1;
    m_p2 = np2;
  endtask

  // One video frame: inputs settle, then a vsync falling edge with the expected result queued.
  task automatic frame(input int a1, input int a2, input bit st_n);
    exp_t e;
    @(posedge clk); #1;
    adc_p1 = 12'(a1); adc_p2 = 12'(a2); start_n = st_n;
    repeat (3) @(posedge clk);
    #1;
    vga_vs = 1'b0;
    m_step(a1, a2, st_n);
    e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
    e.sl = m_sl; e.sr = m_sr; e.go = (m_mode == 2) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    vga_vs = 1'b1;
    @(posedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pongbar1_y", int'(pongbar1_y), 220);
    chk("rst_pongbar2_y", int'(pongbar2_y), 220);
    chk("rst_bal_x", int'(bal_x), 320);
    chk("rst_bal_y", int'(bal_y), 240);
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    chk("rst_game_over", int'(game_over), 0);
  endtask

  // Monitor: outputs are valid one clock after the vsync falling edge.
  logic tb_vs_q = 1'b1;
  logic out_evt = 1'b0;
  always @(posedge clk) begin
    tb_vs_q <= vga_vs;
    out_evt <= reset_n && tb_vs_q && !vga_vs;
  end

  always @(negedge clk) begin
    if (out_evt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pongbar1_y", int'(pongbar1_y), e.p1);
        chk("pongbar2_y", int'(pongbar2_y), e.p2);
        chk("bal_x", int'(bal_x), e.bx);
        chk("bal_y", int'(bal_y), e.by);
        chk("score_l", int'(score_l), e.sl);
        chk("score_r", int'(score_r), e.sr);
        chk("game_over", int'(game_over), e.go);
      end
    end
  end

  initial begin
    int a1, a2;
    reset_n = 1'b0; vga_vs = 1'b1; start_n = 1'b1; adc_p1 = '0; adc_p2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    m_reset();
    reset_n = 1'b1;

    frame(12'hFFF, 12'h400, 1'b1);

    // Random play; stray start presses outside game-over must be ignored.
    for (int i = 0; i < 1500; i++) begin
      frame($urandom_range(0, 4095), $urandom_range(0, 4095), ($urandom_range(0, 15) != 0));
    end

    // Park both paddles away from the ball until someone reaches the winning score.
    for (int i = 0; i < 4000 && m_mode != 2; i++) begin
      a1 = (m_by < 240) ? 4095 : 0;
      frame(a1, a1, 1'b1);
    end
    chk("game_over_reached", int'(game_over), 1);

    for (int i = 0; i < 5; i++) frame($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1);
    frame($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);
    for (int i = 0; i < 100; i++) begin
      frame($urandom_range(0, 4095), $urandom_range(0, 4095), ($urandom_range(0, 7) != 0));
    end

    // Asynchronous reset mid-play: outputs must drop immediately, without a clock edge.
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      a2 = $urandom_range(0, 4095);
      frame($urandom_range(0, 4095), a2, 1'b1);
    end

    @(posedge clk); @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
